// File: rtl/cpu_run_ctrl.sv
// Run controller: gates the CPU for a limited number of cycles or until halt,
// then streams the register file out over a valid/ready port. Optional XOR checksum under RUN_CTRL_CHECKSUM_EN.
module cpu_run_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NREG      = 12,
    parameter int CNT_W     = 16,
    parameter int END_COUNT = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  limit_i,
    input  logic              halt_i,
    output logic              cpu_en_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // RUN   | CPU enabled, counting cycles
    // DUMP  | CPU frozen, streaming registers 0..NREG-1
    // DONE  | dump complete, results held until next start
    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

    localparam logic [CNT_W-1:0]  END_LIM  = CNT_W'(END_COUNT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  limit_q, limit_nxt;
    logic [CNT_W-1:0]  cycles, cycles_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0]  eff_limit;
    logic              start_ok;
    logic              xfer;
    logic              hit;

    assign eff_limit = (limit_i == '0) ? END_LIM : limit_i;
    assign start_ok  = start_i && ((state == IDLE) || (state == DONE));
    assign xfer      = (state == DUMP) && dump_ready_i;
    // Compare one bit wider so cycles+1 cannot wrap before reaching the limit.
    assign hit       = (({1'b0, cycles} + (CNT_W+1)'(1)) == {1'b0, limit_q});

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            limit_q <= '0;
            cycles  <= '0;
            idx     <= '0;
        end else begin
            state   <= state_nxt;
            limit_q <= limit_nxt;
            cycles  <= cycles_nxt;
            idx     <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        limit_nxt    = limit_q;
        cycles_nxt   = cycles;
        idx_nxt      = idx;
        cpu_en_o     = 1'b0;
        dump_valid_o = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    limit_nxt  = eff_limit;
                    cycles_nxt = '0;
                    idx_nxt    = '0;
                    state_nxt  = (eff_limit == '0) ? DUMP : RUN;
                end
            end
            RUN: begin
                cpu_en_o = 1'b1;
                if (cycles != '1) begin
                    cycles_nxt = cycles + CNT_W'(1);
                end
                if (halt_i || hit) begin
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                dump_valid_o = 1'b1;
                if (dump_ready_i) begin
                    // Index stays on the last word so it never overruns the address range.
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done_o      = (state == DONE);
    assign cycles_o    = cycles;
    assign rf_addr_o   = idx;
    assign dump_addr_o = idx;
    assign dump_data_o = dump_valid_o ? rf_data_i : '0;

`ifdef RUN_CTRL_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum ^ dump_data_o;
        end
    end

    assign checksum_o = csum;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected dump words are queued at start
// and popped on each observed handshake; run length, timing and holds are checked inline.
module tb_cpu_run_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 12;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  limit = '0;
    logic              halt = 1'b0;
    logic              cpu_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic [CNT_W-1:0]  cycles;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] rf [0:31];
    word_t             sb [$];
    word_t             w;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    logic              held    = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;

    assign rf_data = rf[rf_addr];

    cpu_run_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W), .END_COUNT(5)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .limit_i(limit), .halt_i(halt),
        .cpu_en_o(cpu_en), .rf_addr_o(rf_addr), .rf_data_i(rf_data),
        .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_addr_o(dump_addr),
        .dump_data_o(dump_data), .cycles_o(cycles), .done_o(done), .checksum_o(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    // Handshake monitor: pops the scoreboard and checks holds under back-pressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (dump_valid) begin
            if (held) begin
                check("hold_addr", 64'(dump_addr), 64'(prev_addr));
                check("hold_data", 64'(dump_data), 64'(prev_data));
            end
            if (dump_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    w = sb.pop_front();
                    check("dump_addr", 64'(dump_addr), 64'(w.addr));
                    check("dump_data", 64'(dump_data), 64'(w.data));
                end
            end
            held      = !dump_ready;
            prev_addr = dump_addr;
            prev_data = dump_data;
        end else begin
            held = 1'b0;
        end
    end

    task automatic push_expected(output logic [DATA_W-1:0] exp_cs);
        exp_cs = '0;
        for (int i = 0; i < NREG; i++) begin
            sb.push_back('{addr: ADDR_W'(i), data: rf[i]});
            exp_cs ^= rf[i];
        end
`ifndef RUN_CTRL_CHECKSUM_EN
        exp_cs = '0;
`endif
    endtask

    task automatic run_test(input logic [CNT_W-1:0] lim, input int halt_at, input int exp_en,
                            input int mode, input bit poke_start, input bit chk_total);
        logic [DATA_W-1:0] exp_cs;
        int n, k, s;
        push_expected(exp_cs);
        dump_ready = rdy(mode, 0);
        @(posedge clk); #1;
        start = 1'b1;
        limit = lim;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        n = 0;
        while (n < 200) begin
            halt = (n + 1 == halt_at);
            @(negedge clk);
            if (n == 0) begin
                check("run_cycles_clr", 64'(cycles), 64'd0);
                check("run_done_clr", 64'(done), 64'd0);
            end
            if (!cpu_en) break;
            check("run_cycles", 64'(cycles), 64'(n));
            n++;
            @(posedge clk); #1;
        end
        halt = 1'b0;
        check("en_cycles", 64'(n), 64'(exp_en));
        check("cycles_final", 64'(cycles), 64'(exp_en));
        check("dump_start", 64'(dump_valid), 64'd1);
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
            dump_ready = rdy(mode, k);
            start = poke_start && (k == 3);
        end
        start = 1'b0;
        check("done", 64'(done), 64'd1);
        if (chk_total) check("total_cycles", 64'(cyc - s), 64'(exp_en + NREG));
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("checksum", 64'(checksum), 64'(exp_cs));
        check("valid_in_done", 64'(dump_valid), 64'd0);
        check("cpu_en_in_done", 64'(cpu_en), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("cycles_held", 64'(cycles), 64'(exp_en));
        check("done_held", 64'(done), 64'd1);
        check("checksum_held", 64'(checksum), 64'(exp_cs));
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_en"}, 64'(cpu_en), 64'd0);
        check({tag, "_valid"}, 64'(dump_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_cycles"}, 64'(cycles), 64'd0);
        check({tag, "_rf_addr"}, 64'(rf_addr), 64'd0);
        check({tag, "_dump_addr"}, 64'(dump_addr), 64'd0);
        check({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] cs_unused;
        int t;
        for (int i = 0; i < 32; i++) rf[i] = DATA_W'(i + 1);
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_test('0, 0, 5, 0, 1'b0, 1'b1);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_test(16'd20, 7, 7, 0, 1'b1, 1'b1);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_test(16'hFFFF, 3, 3, 1, 1'b0, 1'b0);

        // Reset asserted while word 4 is on the port.
        push_expected(cs_unused);
        dump_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        limit = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (dump_valid && dump_addr == ADDR_W'(4)) break;
            t++;
        end
        check("reach_word4", 64'(dump_valid && dump_addr == ADDR_W'(4)), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        @(posedge clk); #1;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_test(16'd9, 0, 9, 1, 1'b0, 1'b0);
        run_test('0, 0, 5, 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
